// File: rtl/scan_chain_tester.sv
// Scan-test controller: shifts a pattern into a scan chain, pulses one capture
// cycle, shifts the response out and scores it against an expected vector under a care mask.
module scan_chain_tester #(
    parameter int CHAIN_LEN = 4,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pattern,
    input  logic [CHAIN_LEN-1:0] expected,
    input  logic [CHAIN_LEN-1:0] care_mask,
    input  logic                 scan_out,
    output logic                 scan_enable,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CHAIN_LEN-1:0] response,
    output logic [CNT_W-1:0]     pattern_count,
    output logic [CNT_W-1:0]     fail_count
);

    localparam int CW = $clog2(CHAIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_IN,
        S_CAPTURE,
        S_SHIFT_OUT,
        S_DONE
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [CW-1:0]        bit_cnt;
    logic                 last_bit;
    logic [CHAIN_LEN-1:0] pat_sr;
    logic [CHAIN_LEN-1:0] exp_q;
    logic [CHAIN_LEN-1:0] mask_q;
    logic [CHAIN_LEN-2:0] resp_sr;
    logic [CHAIN_LEN-1:0] resp_next;
    logic                 run_fail;

    assign last_bit  = (bit_cnt == CW'(CHAIN_LEN - 1));
    // The final sample is taken straight from scan_out so the result is ready on entry to DONE.
    assign resp_next = {resp_sr, scan_out};
    assign run_fail  = (((resp_next ^ exp_q) & mask_q) != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        // NOTE: assigning the default before the case keeps every path driven, so no latch is inferred.
        next_state = state;
        case (state)
            S_IDLE:      if (start)    next_state = S_SHIFT_IN;
            S_SHIFT_IN:  if (last_bit) next_state = S_CAPTURE;
            S_CAPTURE:                 next_state = S_SHIFT_OUT;
            S_SHIFT_OUT: if (last_bit) next_state = S_DONE;
            S_DONE:                    next_state = S_IDLE;
            default:                   next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            scan_enable   <= 1'b0;
            scan_in       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            response      <= '0;
            pattern_count <= '0;
            fail_count    <= '0;
            bit_cnt       <= '0;
            pat_sr        <= '0;
            exp_q         <= '0;
            mask_q        <= '0;
            resp_sr       <= '0;
        end else begin
            scan_enable <= (next_state == S_SHIFT_IN) || (next_state == S_SHIFT_OUT);
            busy        <= (next_state != S_IDLE);
            done        <= (next_state == S_DONE);
            bit_cnt     <= (next_state != state) ? '0 : bit_cnt + CW'(1);
            scan_in     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        scan_in <= pattern[CHAIN_LEN-1];
                        pat_sr  <= pattern << 1;
                        exp_q   <= expected;
                        mask_q  <= care_mask;
                    end
                end
                S_SHIFT_IN: begin
                    if (!last_bit) begin
                        scan_in <= pat_sr[CHAIN_LEN-1];
                        pat_sr  <= pat_sr << 1;
                    end
                end
                S_SHIFT_OUT: begin
                    resp_sr <= resp_next[CHAIN_LEN-2:0];
                    if (last_bit) begin
                        response <= resp_next;
                        pass     <= !run_fail;
                        if (pattern_count != '1) pattern_count <= pattern_count + CNT_W'(1);
                        if (run_fail && (fail_count != '1)) fail_count <= fail_count + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_chain_tester.sv
// Bench for scan_chain_tester: two instances (8-bit and 2-bit counters), each driving
// a four-flop hold chain; results are scored through an expected-result queue.
module tb_scan_chain_tester;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] pattern = '0;
    logic [N-1:0] expected = '0;
    logic [N-1:0] care_mask = '0;

    logic         so_a, se_a, si_a, busy_a, done_a, pass_a;
    logic [N-1:0] resp_a, chain_a;
    logic [7:0]   pc_a, fc_a;
    logic         so_b, se_b, si_b, busy_b, done_b, pass_b;
    logic [N-1:0] resp_b, chain_b;
    logic [1:0]   pc_b, fc_b;

    always #5 clk = ~clk;

    scan_chain_tester #(.CHAIN_LEN(N), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .expected(expected),
        .care_mask(care_mask), .scan_out(so_a), .scan_enable(se_a), .scan_in(si_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .response(resp_a),
        .pattern_count(pc_a), .fail_count(fc_a)
    );

    scan_chain_tester #(.CHAIN_LEN(N), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .expected(expected),
        .care_mask(care_mask), .scan_out(so_b), .scan_enable(se_b), .scan_in(si_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .response(resp_b),
        .pattern_count(pc_b), .fail_count(fc_b)
    );

    // Scan chains with functional D tied to Q, so the capture cycle holds the shifted-in value.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_a <= '0;
        else if (se_a) chain_a <= {chain_a[N-2:0], si_a};
    end
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_b <= '0;
        else if (se_b) chain_b <= {chain_b[N-2:0], si_b};
    end
    assign so_a = chain_a[N-1];
    assign so_b = chain_b[N-1];

    typedef struct {
        logic [N-1:0] resp;
        logic         pass;
        logic [7:0]   pc;
        logic [7:0]   fc;
        logic [1:0]   pc2;
        logic [1:0]   fc2;
    } exp_t;

    typedef struct {
        logic [N-1:0] pat;
        logic [N-1:0] exp;
        logic [N-1:0] mask;
        logic         pass;
    } vec_t;

    exp_t sb[$];
    exp_t mon_r;
    int   tests = 0;
    int   fails = 0;
    int   m_pc = 0;
    int   m_fc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic push_expected(input logic [N-1:0] pat, input logic ok);
        exp_t r;
        m_pc++;
        if (!ok) m_fc++;
        r.resp = pat;
        r.pass = ok;
        r.pc   = 8'(sat(m_pc, 255));
        r.fc   = 8'(sat(m_fc, 255));
        r.pc2  = 2'(sat(m_pc, 3));
        r.fc2  = 2'(sat(m_fc, 3));
        sb.push_back(r);
    endtask

    always @(negedge clk) begin
        if (rst_n && done_a) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_r = sb.pop_front();
                check("response",       resp_a, mon_r.resp);
                check("pass",           pass_a, mon_r.pass);
                check("pattern_count",  pc_a,   mon_r.pc);
                check("fail_count",     fc_a,   mon_r.fc);
                check("sat_done",       done_b, 1);
                check("sat_response",   resp_b, mon_r.resp);
                check("sat_pattern_cnt", pc_b,  mon_r.pc2);
                check("sat_fail_cnt",   fc_b,   mon_r.fc2);
            end
        end
    end

    task automatic scramble_inputs();
        pattern   = N'($urandom);
        expected  = N'($urandom);
        care_mask = N'($urandom);
    endtask

    // Accept one run, then scramble inputs and wait (bounded) until the DUT is idle again.
    task automatic start_run(input logic [N-1:0] pat, input logic [N-1:0] ex,
                             input logic [N-1:0] mask, input logic ok);
        @(negedge clk);
        pattern = pat; expected = ex; care_mask = mask; start = 1'b1;
        push_expected(pat, ok);
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
        for (int i = 0; i < 3 * N + 10; i++) begin
            if (!busy_a) break;
            @(negedge clk);
        end
        check("run_end_idle", busy_a, 0);
    endtask

    // Cycle-by-cycle check of one passing run; ends in the IDLE cycle after DONE.
    task automatic run_detailed(input string tag, input logic [N-1:0] pat);
        @(negedge clk);
        pattern = pat; expected = pat; care_mask = '1; start = 1'b1;
        push_expected(pat, 1'b1);
        @(negedge clk);
        start = 1'b0;
        scramble_inputs();
        for (int n = 1; n <= 2 * N + 3; n++) begin
            if (n > 1) @(negedge clk);
            check({tag, "_scan_in"},     si_a,   (n <= N) ? pat[N-n] : 1'b0);
            check({tag, "_scan_enable"}, se_a,   (n <= N) || (n >= N + 2 && n <= 2 * N + 1));
            check({tag, "_busy"},        busy_a, n <= 2 * N + 2);
            check({tag, "_done"},        done_a, n == 2 * N + 2);
        end
    endtask

    vec_t tbl[7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b1011, 4'b1001, 4'b1111, 1'b0};
        tbl[1] = '{4'b1011, 4'b1001, 4'b1101, 1'b1};
        tbl[2] = '{4'b0000, 4'b0000, 4'b1111, 1'b1};
        tbl[3] = '{4'b1111, 4'b1110, 4'b1111, 1'b0};
        tbl[4] = '{4'b0110, 4'b1001, 4'b0000, 1'b1};
        tbl[5] = '{4'b1000, 4'b0000, 4'b0111, 1'b1};
        tbl[6] = '{4'b0001, 4'b0000, 4'b0001, 1'b0};

        // Reset with random inputs, then release with start low.
        start = 1'($urandom);
        scramble_inputs();
        repeat (3) @(negedge clk);
        check("rst_scan_enable", se_a, 0);
        check("rst_scan_in",     si_a, 0);
        check("rst_busy",        busy_a, 0);
        check("rst_done",        done_a, 0);
        check("rst_pass",        pass_a, 0);
        check("rst_response",    resp_a, 0);
        check("rst_pattern_cnt", pc_a, 0);
        check("rst_fail_cnt",    fc_a, 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_busy", busy_a, 0);
            check("post_rst_se",   se_a, 0);
            check("post_rst_cnt",  pc_a, 0);
        end

        run_detailed("run1", 4'b1011);

        foreach (tbl[i]) start_run(tbl[i].pat, tbl[i].exp, tbl[i].mask, tbl[i].pass);

        // Held start: accepts at E0, E0+11 and E0+22.
        @(negedge clk);
        pattern = 4'b0110; expected = 4'b0110; care_mask = '1; start = 1'b1;
        repeat (3) push_expected(4'b0110, 1'b1);
        for (int n = 1; n <= 34; n++) begin
            @(negedge clk);
            if (n == 30) start = 1'b0;
            check("held_done", done_a, (n % 11) == 10);
            if (n <= 33) check("held_busy", busy_a, (n % 11) != 0);
        end

        // Start asserted only in the DONE cycle must not begin a run.
        @(negedge clk);
        pattern = 4'b1100; expected = 4'b1100; care_mask = '1; start = 1'b1;
        push_expected(4'b1100, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (2 * N + 1) @(negedge clk);
        check("in_done_cycle", done_a, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            check("done_start_ignored", busy_a, 0);
            @(negedge clk);
        end

        // Reset during SHIFT_OUT cycle 7: outputs clear before the next edge, run not counted.
        pattern = 4'b1011; expected = 4'b1011; care_mask = '1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_abort_se", se_a, 1);
        rst_n = 1'b0;
        #1;
        check("abort_se",       se_a, 0);
        check("abort_busy",     busy_a, 0);
        check("abort_pc",       pc_a, 0);
        check("abort_fc",       fc_a, 0);
        check("abort_pass",     pass_a, 0);
        check("abort_response", resp_a, 0);
        check("abort_sat_pc",   pc_b, 0);
        m_pc = 0;
        m_fc = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_detailed("rerun", 4'b1011);

        // Saturation: 2-bit counters stop at 3.
        for (int i = 0; i < 5; i++) begin
            logic [N-1:0] p;
            p = N'($urandom);
            start_run(p, ~p, 4'b1111, 1'b0);
        end
        check("sat_final_pc", pc_b, 3);
        check("sat_final_fc", fc_b, 3);
        check("wide_final_pc", pc_a, 6);
        check("wide_final_fc", fc_a, 5);
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scan_chain_tester.md
# scan_chain_tester

Scan-test controller that drives the `scan_in` / `scan_enable` side of a chain of `scan_dff` cells and observes the far end of the chain. For each test pattern it:
- shifts the stimulus in,
- pulses one functional capture cycle,
- shifts the response out,
- compares the response against an expected vector under a care mask, and counts pass/fail.

It sits between the ATPG pattern source (bench or on-chip memory) and the FSM's scan chain. It is the stimulus and observation end of the chain.

## Interface
- `CHAIN_LEN`, default 4: number of flops in the scan chain (≥2).
- `CNT_W`, default 8: width of the pattern and fail counters.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: request one test run; sampled only in IDLE.
- `pattern`  input  CHAIN_LEN: stimulus; bit k lands in chain position k (position 0 is fed by `scan_in`).
- `expected`  input  CHAIN_LEN: expected captured value per chain position.
- `care_mask`  input  CHAIN_LEN: 1 = compare this bit, 0 = don't-care (X).
- `scan_out`  input  1: Q of chain position CHAIN_LEN-1.
- `scan_enable`  output  1: drives SE of every chain flop.
- `scan_in`  output  1: drives SI of chain position 0.
- `busy`  output  1: high in every state except IDLE.
- `done`  output  1: one-cycle pulse when a run completes.
- `pass`  output  1: result of the last completed run.
- `response`  output  CHAIN_LEN: captured chain contents of the last completed run (bit k = position k).
- `pattern_count`  output  CNT_W: completed runs since reset, saturating.
- `fail_count`  output  CNT_W: failing runs since reset, saturating.

## Operation
- All outputs are registered (Moore). Reset value of every output is 0.
- IDLE:
  - `scan_enable`=0, `scan_in`=0.
  - If `start`=1: latch `pattern`, `expected` and `care_mask` into internal registers, clear the shift counter, go to SHIFT_IN.
  - The input vectors may change after acceptance.
- SHIFT_IN, CHAIN_LEN cycles:
  - `scan_enable`=1.
  - `scan_in` carries the latched pattern MSB first: pattern[CHAIN_LEN-1], then pattern[CHAIN_LEN-2], and so on.
  - After the last cycle, go to CAPTURE.
- CAPTURE, 1 cycle: `scan_enable`=0, `scan_in`=0. The chain loads its functional D inputs.
- SHIFT_OUT, CHAIN_LEN cycles:
  - `scan_enable`=1, `scan_in`=0 (zero fill).
  - At the end of each cycle, sample `scan_out` into a shift register, position CHAIN_LEN-1 first.
  - After the last cycle, go to DONE.
- DONE, 1 cycle:
  - `done`=1.
  - `response` = assembled capture.
  - `pass` = (((response ^ expected) & care_mask) == 0).
  - `pattern_count` += 1, saturating at 2^CNT_W-1.
  - `fail_count` += 1 if fail, saturating.
  - Next state is IDLE.
- `start` is ignored in all non-IDLE states, including DONE. A held `start` re-triggers only once back in IDLE.
- `response`, `pass` and the counters hold their values until the next DONE.
- An all-zero `care_mask` always passes.
- `rst_n` low at any time (including mid-shift): immediately return to IDLE and zero all outputs, counters and latched vectors. An aborted run is not counted.

## Timing
- Let `start` be sampled high at rising edge E0. Cycle n is the cycle after edge E0+n-1.
  - SHIFT_IN: cycles 1..N (N = CHAIN_LEN).
  - CAPTURE: cycle N+1.
  - SHIFT_OUT: cycles N+2..2N+1.
  - DONE: cycle 2N+2.
  - IDLE: cycle 2N+3. The earliest next `start` is sampled at the end of this cycle.
- Run length: 2N+2 cycles from acceptance to `done`. `busy` is high for exactly 2N+2 cycles.
- `scan_out` must be stable at each rising edge in SHIFT_OUT. The chain flops update on the same edge, so no extra pipeline delay is allowed.

## Test plan
Bench setup: CHAIN_LEN=4. The chain is 4 `scan_dff` with functional D tied to its own Q (hold), so captured = shifted-in.
1. Reset: assert `rst_n`=0 with random inputs → all outputs 0. Release with `start`=0 → outputs stay 0 and `busy`=0.
2. Passing run: `pattern`=1011, `expected`=1011, `care_mask`=1111, `start` pulse →
   - `scan_in` sequence 1,1,0,1 in cycles 1–4;
   - `scan_enable` = 1,1,1,1,0,1,1,1,1;
   - `done` in cycle 10 with `response`=1011, `pass`=1;
   - `pattern_count`=1, `fail_count`=0.
3. Failing run and masking:
   - `expected`=1001, `care_mask`=1111 → `pass`=0, `fail_count`=1.
   - Repeat with `care_mask`=1101 → `pass`=1; `fail_count` stays 1, `pattern_count`=3.
4. `start` held high for 30 cycles → runs start at E0 and again after each IDLE cycle, with exactly one `done` per 11 cycles. `start` asserted during DONE alone → no run.
5. Mid-run reset: drop `rst_n` in SHIFT_OUT cycle 7 →
   - `scan_enable`, `busy` and the counters go to 0 asynchronously, before the next edge;
   - no `done` is produced;
   - after release, a new run behaves exactly as in scenario 2.
6. Saturation: CNT_W=2, run 5 failing patterns → `fail_count` and `pattern_count` stop at 3.
